// File: rtl/dot_acc8.sv
// dot_acc8: accumulates a run of signed 8-bit products and returns the saturated sum with sticky overflow.
module dot_acc8 #(
    parameter int MAXLEN = 5,
    parameter int ACCW   = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        len,
    input  logic signed [7:0] prod,
    input  logic              prod_ovf,
    input  logic              in_valid,
    output logic              in_ready,
    output logic signed [7:0] result,
    output logic              overflow,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    localparam logic signed [ACCW-1:0] sat_hi = ACCW'(127);
    localparam logic signed [ACCW-1:0] sat_lo = -ACCW'(128);

    state_t                 state;
    logic signed [ACCW-1:0] acc;
    logic signed [ACCW-1:0] sum;
    logic [2:0]             cnt;
    logic [2:0]             elen;
    logic [2:0]             len_eff;
    logic                   sticky;
    logic                   hi;
    logic                   lo;
    logic                   last;

    always_comb begin
        len_eff = (len > 3'(MAXLEN)) ? 3'(MAXLEN) : len;
        sum     = acc + {{(ACCW-8){prod[7]}}, prod};
        hi      = sum > sat_hi;
        lo      = sum < sat_lo;
        last    = 3'(cnt + 3'd1) == elen;
    end

    assign in_ready  = state == ACC;
    assign out_valid = state == DONE;
    assign busy      = state != IDLE;

    // Saturation is applied only to the final sum, captured as the FSM enters DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            acc      <= '0;
            cnt      <= '0;
            elen     <= '0;
            sticky   <= 1'b0;
            result   <= '0;
            overflow <= 1'b0;
        end else if (state == IDLE) begin
            if (start) begin
                elen   <= len_eff;
                acc    <= '0;
                cnt    <= '0;
                sticky <= 1'b0;
                if (len_eff == 3'd0) begin
                    state    <= DONE;
                    result   <= '0;
                    overflow <= 1'b0;
                end else begin
                    state <= ACC;
                end
            end
        end else if (state == ACC) begin
            if (in_valid) begin
                acc    <= sum;
                cnt    <= 3'(cnt + 3'd1);
                sticky <= sticky | prod_ovf;
                if (last) begin
                    state    <= DONE;
                    result   <= hi ? 8'sh7f : lo ? 8'sh80 : sum[7:0];
                    overflow <= sticky | prod_ovf | hi | lo;
                end
            end
        end else if (out_ready) begin
            state <= IDLE;
        end
    end
endmodule

// File: tb/tb_dot_acc8.sv
// tb_dot_acc8: directed and randomized runs of dot_acc8 checked against an arithmetic reference model.
module tb_dot_acc8;
    localparam int MAXLEN = 5;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [2:0]        len = '0;
    logic signed [7:0] prod = '0;
    logic              prod_ovf = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic signed [7:0] result;
    logic              overflow;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic              busy;

    int checks = 0;
    int errors = 0;
    int pq[$];
    bit oq[$];

    dot_acc8 #(.MAXLEN(MAXLEN), .ACCW(12)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .prod(prod),
        .prod_ovf(prod_ovf), .in_valid(in_valid), .in_ready(in_ready),
        .result(result), .overflow(overflow), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference: clamp the length, sum the first eff products exactly, then saturate once.
    function automatic void model(input int l, output int eff, output int res, output bit ov);
        int s = 0;
        eff = (l > MAXLEN) ? MAXLEN : l;
        ov  = 1'b0;
        for (int i = 0; i < eff; i++) begin
            s  += pq[i];
            ov |= oq[i];
        end
        res = (s > 127) ? 127 : (s < -128) ? -128 : s;
        if (s > 127 || s < -128) ov = 1'b1;
    endfunction

    task automatic run(input int l, input int gap, input int stall);
        int eff, er;
        bit eo;
        model(l, eff, er, eo);
        out_ready = (stall == 0);
        start = 1'b1;
        len = 3'(l);
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < eff; i++) begin
            for (int g = 0; g < gap; g++) begin
                start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
            end
            chk("in_ready", in_ready, 1);
            in_valid = 1'b1;
            prod = 8'(pq[i]);
            prod_ovf = oq[i];
            @(posedge clk); #1;
            in_valid = 1'b0;
            if (i < eff - 1) chk("early_out_valid", out_valid, 0);
        end
        chk("out_valid", out_valid, 1);
        chk("result", result, 8'(er));
        chk("overflow", overflow, eo);
        for (int s = 0; s < stall; s++) begin
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            chk("stall_valid", out_valid, 1);
            chk("stall_result", result, 8'(er));
            chk("stall_overflow", overflow, eo);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("pulse_end", out_valid, 0);
        chk("idle_busy", busy, 0);
        chk("hold_result", result, 8'(er));
    endtask

    initial begin
        #1;
        chk("rst_result", result, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        pq = '{10, 20, 30};          oq = '{0, 0, 0};          run(3, 0, 0);
        pq = '{100, 100};            oq = '{0, 0};             run(2, 0, 0);
        pq = '{-128, -128, -128, -128, -128}; oq = '{0, 0, 0, 0, 0}; run(5, 0, 0);
        pq = '{100, 100, -100};      oq = '{0, 0, 0};          run(3, 0, 0);
        pq = '{5, 3};                oq = '{1, 0};             run(2, 0, 0);
        pq = '{};                    oq = '{};                 run(0, 0, 0);
        pq = '{3, 4};                oq = '{0, 0};             run(2, 3, 4);

        start = 1'b1;
        len = 3'd3;
        @(posedge clk); #1;
        start = 1'b0;
        in_valid = 1'b1;
        prod = 8'sd1;
        prod_ovf = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_result", result, 0);
        chk("mid_rst_overflow", overflow, 0);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_in_ready", in_ready, 0);
        chk("mid_rst_busy", busy, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("post_rst_out_valid", out_valid, 0);
            chk("post_rst_busy", busy, 0);
        end

        pq = '{1, 1, 1, 1, 1, 1, 1}; oq = '{0, 0, 0, 0, 0, 0, 0}; run(7, 0, 0);

        for (int r = 0; r < 24; r++) begin
            pq = '{};
            oq = '{};
            for (int i = 0; i < 7; i++) begin
                pq.push_back(int'($urandom_range(255)) - 128);
                oq.push_back($urandom_range(7) == 0);
            end
            run(int'($urandom_range(7)), int'($urandom_range(2)), int'($urandom_range(2)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
